// File: rtl/add_chunk_sequencer.sv
// Multi-cycle sequencer that feeds 5-bit chunks to an external carry-lookahead slice and assembles ADD/SUB results.
// Optional multi-word carry chaining is enabled by defining ADD_CHUNK_SEQ_CHAIN_EN.
module add_chunk_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             chain,
    output logic [4:0]       add_a,
    output logic [4:0]       add_b,
    output logic             add_cin,
    input  logic [4:0]       add_r,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N     = (WIDTH + 4) / 5;
    localparam int PW    = 5 * N;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam bit EXACT = (WIDTH % 5 == 0);
    // Position of the carry out of bit WIDTH-1 inside the zero-padded last chunk.
    localparam int CB    = EXACT ? 0 : WIDTH - 5 * (N - 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

`ifdef ADD_CHUNK_SEQ_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    a_pad, b_pad;
    logic [WIDTH-1:0] res_nx;
    logic             cout_nx;
    logic             carry_init;
    logic             accept;
    int               base;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? RUN : IDLE;
            RUN:        state_nx = (idx == LAST) ? DONE : RUN;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        base  = 5 * int'(idx);
        a_pad = '0;
        b_pad = '0;
        a_pad[WIDTH-1:0] = a_q;
        b_pad[WIDTH-1:0] = b_q;
        busy    = (state == RUN);
        done    = (state == DONE);
        add_a   = busy ? a_pad[base +: 5] : 5'd0;
        add_b   = busy ? b_pad[base +: 5] : 5'd0;
        add_cin = busy ? carry : 1'b0;
    end

    // Merge the current slice sum into the partial result, dropping padding bits.
    always_comb begin
        res_nx = result;
        for (int j = 0; j < 5; j++) begin
            if (base + j < WIDTH) res_nx[base + j] = add_r[j];
        end
        cout_nx = EXACT ? add_cout : add_r[CB];
    end

    assign accept     = start && (state != RUN);
    assign carry_init = sub ? 1'b1 : ((CHAIN_EN && chain) ? cout : cin);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= carry_init;
            idx   <= '0;
        end else if (state == RUN) begin
            result <= res_nx;
            carry  <= add_cout;
            idx    <= idx + IW'(1);
            if (idx == LAST) begin
                idx  <= '0;
                cout <= cout_nx;
                ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
                zero <= (res_nx == '0);
            end
        end
    end
endmodule
